// File: rtl/y86_pipe_pkg.sv
// y86_pipe_pkg
// Shared definitions for the five-stage Y86 pipeline: instruction codes,
// the "no register" id, stage status codes, the hazard-controller state
// enum and a helper that classifies exception statuses.
package y86_pipe_pkg;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // Register id meaning "no register"
    localparam logic [3:0] RNONE = 4'hF;

    // Stage status codes
    localparam logic [2:0] BUB = 3'd0;
    localparam logic [2:0] AOK = 3'd1;
    localparam logic [2:0] HLT = 3'd2;
    localparam logic [2:0] ADR = 3'd3;
    localparam logic [2:0] INS = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } ctrl_state_t;

    // True for statuses that must stop the pipeline
    function automatic logic is_exc(input logic [2:0] stat);
        return (stat == HLT) || (stat == ADR) || (stat == INS);
    endfunction

endpackage

// File: rtl/pipe_perf_ctr.sv
// pipe_perf_ctr
// Saturating performance counter: counts up by one on inc, sticks at
// all-ones instead of wrapping.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset (clears the count)
//   clear  synchronous clear
//   inc    count enable for this cycle
//   count  current value
module pipe_perf_ctr #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != '1)) begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central hazard controller for the five-stage Y86 pipeline. Generates the
// stall/bubble controls for the F, D, E, M and W pipeline registers and the
// condition-code write enable, sequences the post-reset flush and the
// exception drain/halt, and keeps five saturating performance counters.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   D_icode, E_icode, M_icode        icodes held in the D/E/M registers
//   E_dstM                           load destination in E (RNONE = none)
//   d_srcA, d_srcB                   decode-stage source registers
//   e_Cnd                            branch condition from execute
//   m_stat, W_stat                   memory / writeback status
//   F_stall, D_stall, W_stall        hold register contents
//   D_bubble, E_bubble, M_bubble     load a bubble into the register
//   set_cc                           condition-code write enable
//   halted, final_stat               pipeline stopped / status that did it
//   cyc_cnt .. ret_cnt               performance counters
module pipe_hazard_ctrl
    import y86_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       E_dstM,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic             e_Cnd,
    input  logic [2:0]       m_stat,
    input  logic [2:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             W_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             set_cc,
    output logic             halted,
    output logic [2:0]       final_stat,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ret_cnt
);

    localparam int N_CNT = 5;

    ctrl_state_t state_reg;
    logic [2:0]  final_stat_reg;

    // Hazard terms
    logic loaduse, ret_haz, mispred, m_exc, w_exc;

    assign loaduse = ((E_icode == IMRMOVQ) || (E_icode == IPOPQ)) &&
                     (E_dstM != RNONE) &&
                     ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign ret_haz = (D_icode == IRET) || (E_icode == IRET) || (M_icode == IRET);
    assign mispred = (E_icode == IJXX) && !e_Cnd;
    assign m_exc   = is_exc(m_stat);
    assign w_exc   = is_exc(W_stat);

    // Control state machine; final_stat is captured on the halt transition
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            final_stat_reg <= 3'd0;
        end else begin
            case (state_reg)
                ST_IDLE: state_reg <= ST_RUN;
                ST_RUN: begin
                    if (w_exc) begin
                        state_reg      <= ST_HALTED;
                        final_stat_reg <= W_stat;
                    end else if (m_exc) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_exc) begin
                        state_reg      <= ST_HALTED;
                        final_stat_reg <= W_stat;
                    end
                end
                default: state_reg <= ST_HALTED;
            endcase
        end
    end

    // Pipeline register controls, combinational from inputs and state
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        set_cc   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
            end
            ST_RUN, ST_DRAIN: begin
                F_stall  = (loaduse || ret_haz) && !mispred;
                D_stall  = loaduse;
                // A stall in D must win over a bubble in D
                D_bubble = (mispred || (ret_haz && !loaduse)) && !loaduse;
                E_bubble = mispred || loaduse;
                M_bubble = m_exc || w_exc;
                W_stall  = w_exc;
                set_cc   = (E_icode == IOPQ) && !m_exc && !w_exc;
                if (state_reg == ST_DRAIN) begin
                    // Fetch nothing new and freeze CCs while the fault drains
                    F_stall = 1'b1;
                    set_cc  = 1'b0;
                end
            end
            default: begin
                F_stall  = 1'b1;
                D_bubble = 1'b1;
                E_bubble = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
        endcase
    end

    assign halted     = (state_reg == ST_HALTED);
    assign final_stat = final_stat_reg;

    // Performance counters: index 0 cycles, 1 stalls, 2 bubbles,
    // 3 mispredicts, 4 returns entering D
    logic                 active;
    logic [N_CNT-1:0]     cnt_inc;
    logic [CNT_W-1:0]     cnt_val [N_CNT];

    assign active     = (state_reg == ST_RUN) || (state_reg == ST_DRAIN);
    assign cnt_inc[0] = active;
    assign cnt_inc[1] = active && (F_stall || D_stall);
    assign cnt_inc[2] = active && (D_bubble || E_bubble);
    assign cnt_inc[3] = active && mispred;
    assign cnt_inc[4] = active && (D_icode == IRET) && !D_stall;

    generate
        for (genvar gi = 0; gi < N_CNT; gi++) begin : g_cnt
            pipe_perf_ctr #(.CNT_W(CNT_W)) u_ctr (
                .clk   (clk),
                .rst_n (rst_n),
                .clear (state_reg == ST_IDLE),
                .inc   (cnt_inc[gi]),
                .count (cnt_val[gi])
            );
        end
    endgenerate

    assign cyc_cnt     = cnt_val[0];
    assign stall_cnt   = cnt_val[1];
    assign bubble_cnt  = cnt_val[2];
    assign mispred_cnt = cnt_val[3];
    assign ret_cnt     = cnt_val[4];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl. A 32-bit instance covers the
// control behaviour; a 4-bit-counter instance sharing the same inputs
// covers counter saturation.
module tb_pipe_hazard_ctrl;
    import y86_pipe_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [3:0] D_icode, E_icode, M_icode, E_dstM, d_srcA, d_srcB;
    logic       e_Cnd;
    logic [2:0] m_stat, W_stat;

    logic        F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc, halted;
    logic [2:0]  final_stat;
    logic [31:0] cyc_cnt, stall_cnt, bubble_cnt, mispred_cnt, ret_cnt;

    logic        F_stall4, D_stall4, W_stall4, D_bubble4, E_bubble4, M_bubble4, set_cc4, halted4;
    logic [2:0]  final_stat4;
    logic [3:0]  cyc_cnt4, stall_cnt4, bubble_cnt4, mispred_cnt4, ret_cnt4;

    int errors = 0;
    int checks = 0;

    pipe_hazard_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .W_stall(W_stall),
        .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble),
        .set_cc(set_cc), .halted(halted), .final_stat(final_stat),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .mispred_cnt(mispred_cnt), .ret_cnt(ret_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode),
        .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB), .e_Cnd(e_Cnd),
        .m_stat(m_stat), .W_stat(W_stat),
        .F_stall(F_stall4), .D_stall(D_stall4), .W_stall(W_stall4),
        .D_bubble(D_bubble4), .E_bubble(E_bubble4), .M_bubble(M_bubble4),
        .set_cc(set_cc4), .halted(halted4), .final_stat(final_stat4),
        .cyc_cnt(cyc_cnt4), .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4),
        .mispred_cnt(mispred_cnt4), .ret_cnt(ret_cnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check the seven pipeline controls as a packed vector
    // {F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc}
    task automatic chk_ctl(input string tag, input logic [6:0] exp);
        chk(tag, {25'd0, F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, set_cc},
            {25'd0, exp});
    endtask

    task automatic nop_inputs();
        D_icode = INOP; E_icode = INOP; M_icode = INOP;
        E_dstM = RNONE; d_srcA = RNONE; d_srcB = RNONE;
        e_Cnd = 1'b1; m_stat = AOK; W_stat = AOK;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        nop_inputs();
        tick();
        tick();
        #1;
        $display("step reset: held two cycles");
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_final", {29'd0, final_stat}, 32'd0);
        chk("rst_cyc", cyc_cnt, 32'd0);
        chk("rst_stall", stall_cnt, 32'd0);

        rst_n = 1'b1;
        #1;
        $display("step idle: first cycle after release");
        chk_ctl("idle_ctl", 7'b1001110);
        tick();

        // S0: RUN with NOPs
        #1;
        $display("step run_nop");
        chk_ctl("run_nop_ctl", 7'b0000000);
        chk("run_nop_cyc", cyc_cnt, 32'd0);
        chk("run_nop_bub", bubble_cnt, 32'd0);
        tick();

        // S1: load/use on rA
        E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        $display("step loaduse");
        chk_ctl("loaduse_ctl", 7'b1100100);
        tick();

        // S2: hazard clears after one cycle
        nop_inputs();
        #1;
        $display("step after_loaduse");
        chk_ctl("after_lu_ctl", 7'b0000000);
        chk("lu_stall_cnt", stall_cnt, 32'd1);
        chk("lu_bubble_cnt", bubble_cnt, 32'd1);
        tick();

        // S3: mispredict with IRET in D; ret enters D unstalled
        E_icode = IJXX; e_Cnd = 1'b0; D_icode = IRET;
        #1;
        $display("step mispred");
        chk_ctl("mispred_ctl", 7'b0001100);
        tick();

        // S4
        nop_inputs();
        #1;
        $display("step after_mispred");
        chk("mp_mispred_cnt", mispred_cnt, 32'd1);
        chk("mp_ret_cnt", ret_cnt, 32'd1);
        chk("mp_bubble_cnt", bubble_cnt, 32'd2);
        tick();

        // S5..S7: IRET walks D -> E -> M
        D_icode = IRET;
        #1;
        $display("step ret_in_D");
        chk_ctl("retD_ctl", 7'b1001000);
        tick();
        D_icode = INOP; E_icode = IRET;
        #1;
        $display("step ret_in_E");
        chk_ctl("retE_ctl", 7'b1001000);
        tick();
        E_icode = INOP; M_icode = IRET;
        #1;
        $display("step ret_in_M");
        chk_ctl("retM_ctl", 7'b1001000);
        tick();

        // S8
        nop_inputs();
        #1;
        $display("step after_ret");
        chk_ctl("after_ret_ctl", 7'b0000000);
        chk("ret_ret_cnt", ret_cnt, 32'd2);
        chk("ret_stall_cnt", stall_cnt, 32'd4);
        chk("ret_bubble_cnt", bubble_cnt, 32'd5);
        tick();

        // S9: OPq writes condition codes
        E_icode = IOPQ;
        #1;
        $display("step opq_set_cc");
        chk_ctl("opq_ctl", 7'b0000001);
        tick();

        // S10: memory exception suppresses set_cc
        m_stat = ADR;
        #1;
        $display("step m_exc");
        chk_ctl("mexc_ctl", 7'b0000010);
        chk("mexc_cyc", cyc_cnt, 32'd10);
        tick();

        // S11: DRAIN, writeback exception arrives
        m_stat = AOK; W_stat = ADR;
        #1;
        $display("step drain_w_exc");
        chk_ctl("drain_ctl", 7'b1010010);
        chk("drain_halted", {31'd0, halted}, 32'd0);
        tick();

        // S12: HALTED, counters frozen even under a load/use pattern
        nop_inputs();
        E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcA = 4'd3;
        #1;
        $display("step halted");
        chk_ctl("halt_ctl", 7'b1011110);
        chk("halt_halted", {31'd0, halted}, 32'd1);
        chk("halt_final", {29'd0, final_stat}, 32'd3);
        tick();
        tick();
        #1;
        $display("step halted_frozen");
        chk("frz_cyc", cyc_cnt, 32'd12);
        chk("frz_stall", stall_cnt, 32'd5);
        chk("frz_bubble", bubble_cnt, 32'd5);
        chk("frz_final", {29'd0, final_stat}, 32'd3);

        // Reset one cycle from HALTED
        rst_n = 1'b0;
        tick();
        #1;
        $display("step reset_from_halted");
        chk("rh_halted", {31'd0, halted}, 32'd0);
        chk("rh_final", {29'd0, final_stat}, 32'd0);
        chk("rh_cyc", cyc_cnt, 32'd0);
        chk_ctl("rh_idle_ctl", 7'b1001110);
        rst_n = 1'b1;
        nop_inputs();
        tick();

        // Sustained load/use with IRET in D: stall beats bubble, counters saturate
        for (int i = 0; i < 20; i++) begin
            E_icode = IMRMOVQ; E_dstM = 4'd3; d_srcB = 4'd3; D_icode = IRET;
            #1;
            if (i == 0) begin
                $display("step loaduse_vs_ret");
                chk_ctl("lu_ret_ctl", 7'b1100100);
            end
            if (i == 16) begin
                $display("step sat_mid");
                chk("sat_mid_stall4", {28'd0, stall_cnt4}, 32'hF);
            end
            tick();
        end
        nop_inputs();
        #1;
        $display("step saturation");
        chk("sat_stall4", {28'd0, stall_cnt4}, 32'hF);
        chk("sat_cyc4", {28'd0, cyc_cnt4}, 32'hF);
        chk("sat_stall32", stall_cnt, 32'd20);
        chk("sat_bubble32", bubble_cnt, 32'd20);
        chk("sat_ret32", ret_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the bench always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
